// File: rtl/alu_issue_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_queue_pkg
// Purpose : Shared backend definitions for the ALU issue path: control-vector
//           width, the buffered micro-op record and the one-hot bit positions
//           of the ALU control vector.
// Ports   : none (package)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
package alu_issue_queue_pkg;

  localparam int ALU_OP_W = 14;

  // One micro-op as it travels from decode to execute (83 bits).
  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic [31:0]         src1;
    logic [31:0]         src2;
    logic [4:0]          rd;
  } alu_uop_t;

  // One-hot bit positions inside alu_op.
  localparam int ALU_OP_ADD   = 0;
  localparam int ALU_OP_SUB   = 1;
  localparam int ALU_OP_SLL   = 2;
  localparam int ALU_OP_SLT   = 3;
  localparam int ALU_OP_SLTU  = 4;
  localparam int ALU_OP_XOR   = 5;
  localparam int ALU_OP_SRL   = 6;
  localparam int ALU_OP_SRA   = 7;
  localparam int ALU_OP_OR    = 8;
  localparam int ALU_OP_AND   = 9;
  localparam int ALU_OP_LUI   = 10;
  localparam int ALU_OP_AUIPC = 11;
  localparam int ALU_OP_JAL   = 12;
  localparam int ALU_OP_JALR  = 13;

endpackage
`default_nettype wire

// File: rtl/alu_issue_queue_fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fifo_ptr_ctrl
// Purpose : Reusable circular-buffer pointer controller. Owns the read and
//           write pointers (one extra wrap bit each), full/empty and the
//           occupancy count. Flush has priority over push and pop.
// Ports   : clk, rst_n (async active-low), flush, push, pop  -> inputs
//           wr_idx, rd_idx (storage indices), full, empty, count -> outputs
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
module fifo_ptr_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  output logic [$clog2(DEPTH)-1:0] wr_idx,
  output logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Callers normally qualify push/pop already; the extra guard keeps the
  // pointers consistent even if a caller does not.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Same index with different wrap bits means the writer is a full lap ahead.
  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                  (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign count  = r_wr_ptr - r_rd_ptr;
  assign wr_idx = r_wr_ptr[AW-1:0];
  assign rd_idx = r_rd_ptr[AW-1:0];

endmodule
`default_nettype wire

// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_queue
// Purpose : In-order buffer of decoded ALU micro-ops between decode/regfile
//           read and execute. valid/ready on both sides, synchronous flush.
// Ports   : clk, rst_n (async active-low), flush
//           in_valid/in_ready, in_alu_op, in_src1, in_src2, in_rd  (decode)
//           out_valid/out_ready, out_alu_op, out_src1, out_src2, out_rd (ALU)
//           count - current occupancy
// Config  : ALU_ISSUE_BYPASS_EN - when defined, an empty queue forwards the
//           incoming micro-op to the outputs in the same cycle.
// Revision: 1.0 - initial release
// ============================================================================
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OP_W  = ALU_OP_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_W-1:0]          in_alu_op,
  input  logic [31:0]              in_src1,
  input  logic [31:0]              in_src2,
  input  logic [4:0]               in_rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OP_W-1:0]          out_alu_op,
  output logic [31:0]              out_src1,
  output logic [31:0]              out_src2,
  output logic [4:0]               out_rd,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  alu_uop_t          r_mem [DEPTH];
  alu_uop_t          w_in_uop;
  alu_uop_t          w_head;
  logic [AW-1:0]     w_wr_idx;
  logic [AW-1:0]     w_rd_idx;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  assign w_in_uop.alu_op = in_alu_op;
  assign w_in_uop.src1   = in_src1;
  assign w_in_uop.src2   = in_src2;
  assign w_in_uop.rd     = in_rd;

  // in_ready depends only on stored occupancy, never on out_ready.
  assign in_ready = !w_full;

`ifdef ALU_ISSUE_BYPASS_EN
  logic w_bypass;

  // An empty queue forwards the incoming micro-op straight through; it is
  // only written into storage if the ALU does not take it this cycle.
  assign w_bypass  = w_empty && !flush && in_valid;
  assign out_valid = !w_empty || w_bypass;
  assign w_head    = w_bypass ? w_in_uop : r_mem[w_rd_idx];
  assign w_push    = in_valid && in_ready && !(w_bypass && out_ready);
`else
  assign out_valid = !w_empty;
  assign w_head    = r_mem[w_rd_idx];
  assign w_push    = in_valid && in_ready;
`endif

  // Only stored entries are popped; a bypassed micro-op never occupies a slot.
  assign w_pop = !w_empty && out_ready;

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .push   (w_push),
    .pop    (w_pop),
    .wr_idx (w_wr_idx),
    .rd_idx (w_rd_idx),
    .full   (w_full),
    .empty  (w_empty),
    .count  (count)
  );

  // Payload storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[w_wr_idx] <= w_in_uop;
    end
  end

  assign out_alu_op = w_head.alu_op;
  assign out_src1   = w_head.src1;
  assign out_src2   = w_head.src2;
  assign out_rd     = w_head.rd;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_issue_queue
// Purpose : Self-checking bench for alu_issue_queue (DEPTH=4). Stimulus is
//           directed plus a seeded pseudo-random phase; a scoreboard queue of
//           expected micro-ops is compared against the DUT head each cycle.
// Config  : ALU_ISSUE_BYPASS_EN - adds the same-cycle forwarding case.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_alu_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_alu_op;
  logic [31:0] out_src1;
  logic [31:0] out_src2;
  logic [4:0]  out_rd;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  alu_uop_t exp_q[$];

  alu_issue_queue #(.DEPTH(DEPTH), .OP_W(14)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_alu_op  (in_alu_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_alu_op (out_alu_op),
    .out_src1   (out_src1),
    .out_src2   (out_src2),
    .out_rd     (out_rd),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, then advance past the next rising edge.
  task automatic step(input logic v, input logic [13:0] op, input logic [31:0] s1,
                      input logic [31:0] s2, input logic [4:0] rd,
                      input logic ordy, input logic fl);
    in_valid  = v;
    in_alu_op = op;
    in_src1   = s1;
    in_src2   = s2;
    in_rd     = rd;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 14'h0, 32'h0, 32'h0, 5'd0, ordy, 1'b0);
  endtask

  // Monitor/scoreboard: evaluated mid-cycle, when this cycle's inputs are
  // stable; the model state describes what the DUT holds right now.
  always @(negedge clk) begin
    int       c0;
    bit       acc;
    bit       ov_exp;
    alu_uop_t cur;
    c0  = exp_q.size();
    acc = rst_n && in_valid && (c0 < DEPTH) && !flush;
    cur.alu_op = in_alu_op;
    cur.src1   = in_src1;
    cur.src2   = in_src2;
    cur.rd     = in_rd;
    chk("count", 32'(count), 32'(c0));
    chk("in_ready", 32'(in_ready), 32'(c0 < DEPTH));
`ifdef ALU_ISSUE_BYPASS_EN
    if (acc && c0 == 0) begin
      exp_q.push_back(cur);
      acc = 1'b0;
    end
`endif
    ov_exp = (exp_q.size() > 0);
    chk("out_valid", 32'(out_valid), 32'(ov_exp));
    if (ov_exp) begin
      chk("out_alu_op", 32'(out_alu_op), 32'(exp_q[0].alu_op));
      chk("out_src1", out_src1, exp_q[0].src1);
      chk("out_src2", out_src2, exp_q[0].src2);
      chk("out_rd", 32'(out_rd), 32'(exp_q[0].rd));
      if (out_ready && !flush && rst_n) void'(exp_q.pop_front());
    end
    if (flush && rst_n) exp_q.delete();
    else if (acc) exp_q.push_back(cur);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_alu_op = '0; in_src1 = '0; in_src2 = '0; in_rd = '0;
    out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1'b0);

    // Single push: visible with count 1 the next cycle.
    step(1'b1, 14'h0001, 32'h0000_0005, 32'h0000_0007, 5'd3, 1'b0, 1'b0);
    idle(1'b0);

    // Fill to four, then a fifth offer that must be ignored.
    step(1'b1, 14'h0002, 32'h0000_0011, 32'h0000_0012, 5'd4, 1'b0, 1'b0);
    step(1'b1, 14'h0004, 32'h0000_0021, 32'h0000_0022, 5'd5, 1'b0, 1'b0);
    step(1'b1, 14'h0008, 32'h0000_0031, 32'h0000_0032, 5'd6, 1'b0, 1'b0);
    step(1'b1, 14'h0010, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd7, 1'b0, 1'b0);
    idle(1'b0);

    // Full with a pop and a push offer: pop only, count drops to 3.
    step(1'b1, 14'h0020, 32'h1111_1111, 32'h2222_2222, 5'd8, 1'b1, 1'b0);
    // Drain the remaining three in order, then one empty cycle.
    repeat (4) idle(1'b1);

    // Three entries, then flush with a coincident push that must vanish.
    step(1'b1, 14'h0040, 32'h0000_0041, 32'h0000_0042, 5'd9,  1'b0, 1'b0);
    step(1'b1, 14'h0080, 32'h0000_0051, 32'h0000_0052, 5'd10, 1'b0, 1'b0);
    step(1'b1, 14'h0100, 32'h0000_0061, 32'h0000_0062, 5'd11, 1'b0, 1'b0);
    step(1'b1, 14'h0200, 32'hBAD0_BAD0, 32'hBAD1_BAD1, 5'd12, 1'b0, 1'b1);
    repeat (2) idle(1'b1);

    // Two entries, then an asynchronous reset between clock edges.
    step(1'b1, 14'h0400, 32'h0000_0071, 32'h0000_0072, 5'd13, 1'b0, 1'b0);
    step(1'b1, 14'h0800, 32'h0000_0081, 32'h0000_0082, 5'd14, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1'b0);

`ifdef ALU_ISSUE_BYPASS_EN
    // Empty queue, push with out_ready: forwarded, nothing stored.
    in_valid = 1'b1; in_alu_op = 14'h1000; in_src1 = 32'h0000_00A1;
    in_src2 = 32'h0000_00A2; in_rd = 5'd15; out_ready = 1'b1; flush = 1'b0;
    #1;
    chk("bypass_out_valid", 32'(out_valid), 32'd1);
    chk("bypass_out_src1", out_src1, 32'h0000_00A1);
    chk("bypass_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    idle(1'b0);
`endif

    // Pseudo-random push/pop/flush traffic around the wrap point.
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)),
           14'(1 << $urandom_range(0, 13)),
           $urandom, $urandom, 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 63) == 0));
    end
    repeat (6) idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
